// File: rtl/rv_p4_pkg.sv
// Shared RV-P4 pipeline definitions: PHV geometry, per-PHV metadata and MAU timing.
package rv_p4_pkg;

  localparam int PHV_BITS       = 64;
  localparam int MAU_PIPE_LAT   = 4;
  localparam int MAU_IBUF_DEPTH = 8;

  typedef struct packed {
    logic [3:0] port;
    logic [7:0] seq_tag;
    logic [3:0] flags;
  } phv_meta_t;

  localparam int PHV_META_BITS = $bits(phv_meta_t);

endpackage

// File: rtl/phv_if.sv
// PHV transfer bundle between pipeline stages; src drives data, dst drives ready.
interface phv_if;
  import rv_p4_pkg::*;

  logic                valid;
  logic                ready;
  logic [PHV_BITS-1:0] data;
  phv_meta_t           meta;

  modport src (output valid, output data, output meta, input  ready);
  modport dst (input  valid, input  data, input  meta, output ready);

endinterface

// File: rtl/mau_phv_ibuf.sv
// Inter-stage PHV elastic buffer: unconditional push, early throttle with SKID
// reserved slots, show-ahead valid/ready output, occupancy statistics.
module mau_phv_ibuf
  import rv_p4_pkg::*;
#(
  parameter int DEPTH = MAU_IBUF_DEPTH,
  parameter int SKID  = MAU_PIPE_LAT
) (
  input  logic                       clk_dp,
  input  logic                       rst_dp_n,
  phv_if.dst                         phv_in,
  phv_if.src                         phv_out,
  input  logic                       stat_clr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] hwm,
  output logic [15:0]                ovf_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = PHV_BITS + PHV_META_BITS;

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] RDY_THR  = CW'(DEPTH - SKID);

  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [CW-1:0] hwm_q,    hwm_d;
  logic [15:0]   ovf_q,    ovf_d;
  logic          push, pop, drop;

  always_comb begin
    pop      = (count_q != '0) && phv_out.ready;
    // A full buffer still accepts when the head retires in the same cycle.
    push     = phv_in.valid && ((count_q != CNT_FULL) || pop);
    drop     = phv_in.valid && !push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hwm_d    = hwm_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (stat_clr) begin
      hwm_d = '0;
      ovf_d = '0;
    end else begin
      if (count_d > hwm_q)                 hwm_d = count_d;
      if (drop && (ovf_q != 16'hFFFF))     ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk_dp or negedge rst_dp_n) begin
    if (!rst_dp_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hwm_q    <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hwm_q    <= hwm_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; entries are only observed while count covers them.
  always_ff @(posedge clk_dp) begin
    if (push) mem_q[wr_ptr_q] <= {phv_in.meta, phv_in.data};
  end

  assign {phv_out.meta, phv_out.data} = mem_q[rd_ptr_q];
  assign phv_out.valid = (count_q != '0);
  assign phv_in.ready  = (count_q < RDY_THR);

  assign occupancy = count_q;
  assign hwm       = hwm_q;
  assign ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_mau_phv_ibuf.sv
// Scoreboard bench for mau_phv_ibuf: directed scenarios on the default build,
// randomized traffic with a 4-deep upstream pipe on a DEPTH=6 build.
module tb_mau_phv_ibuf;
  import rv_p4_pkg::*;

  localparam int EW = PHV_BITS + PHV_META_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr0 = 1'b0;
  logic clr1 = 1'b0;
  logic [3:0]  occ0, hwm0;
  logic [2:0]  occ1, hwm1;
  logic [15:0] ovf0, ovf1;

  phv_if in0 ();
  phv_if out0 ();
  phv_if in1 ();
  phv_if out1 ();

  mau_phv_ibuf u_dut (
    .clk_dp    (clk),
    .rst_dp_n  (rst_n),
    .phv_in    (in0),
    .phv_out   (out0),
    .stat_clr  (clr0),
    .occupancy (occ0),
    .hwm       (hwm0),
    .ovf_cnt   (ovf0)
  );

  mau_phv_ibuf #(.DEPTH(6)) u_dut6 (
    .clk_dp    (clk),
    .rst_dp_n  (rst_n),
    .phv_in    (in1),
    .phv_out   (out1),
    .stat_clr  (clr1),
    .occupancy (occ1),
    .hwm       (hwm1),
    .ovf_cnt   (ovf1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  int hwm_m[2];
  int ovf_m[2];
  int sbmax[2];
  int popn[2];
  int pushn[2];
  int unsigned seq = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q0 = {};
    q1 = {};
    for (int k = 0; k < 2; k++) begin
      hwm_m[k] = 0; ovf_m[k] = 0; sbmax[k] = 0;
    end
  endtask

  // Called on the falling edge: compares the DUT's current outputs, then
  // predicts what the next rising edge does.
  task automatic model_step(input int k, input int depth, input logic vo, input logic dn_rdy,
                            input logic iv, input logic ir, input logic clr,
                            input logic [EW-1:0] head, input logic [EW-1:0] ient,
                            input int occ, input int hw, input int ovf);
    logic [EW-1:0] q[$];
    int n;
    bit pop, push_ok;
    if (k == 0) q = q0; else q = q1;
    n = q.size();
    check_eq($sformatf("i%0d.valid", k), 128'(vo), 128'(n != 0));
    check_eq($sformatf("i%0d.occ", k), 128'(occ), 128'(n));
    check_eq($sformatf("i%0d.in_ready", k), 128'(ir), 128'((depth - n) > 4));
    check_eq($sformatf("i%0d.hwm", k), 128'(hw), 128'(hwm_m[k]));
    check_eq($sformatf("i%0d.ovf", k), 128'(ovf), 128'(ovf_m[k]));
    if (n != 0) check_eq($sformatf("i%0d.head", k), 128'(head), 128'(q[0]));
    pop     = (n != 0) && dn_rdy;
    push_ok = iv && ((n < depth) || pop);
    if (pop) begin
      $display("i%0d pop entry=%0h", k, q[0]);
      void'(q.pop_front());
      popn[k]++;
    end
    if (push_ok) begin
      q.push_back(ient);
      pushn[k]++;
    end
    if (clr) begin
      hwm_m[k] = 0; ovf_m[k] = 0;
    end else begin
      if (q.size() > hwm_m[k]) hwm_m[k] = q.size();
      if (iv && !push_ok && ovf_m[k] != 16'hFFFF) ovf_m[k]++;
    end
    if (q.size() > sbmax[k]) sbmax[k] = q.size();
    if (k == 0) q0 = q; else q1 = q;
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else model_step(0, 8, out0.valid, out0.ready, in0.valid, in0.ready, clr0,
                    {out0.meta, out0.data}, {in0.meta, in0.data}, int'(occ0), int'(hwm0), int'(ovf0));
  end

  always @(negedge clk) begin
    if (rst_n)
      model_step(1, 6, out1.valid, out1.ready, in1.valid, in1.ready, clr1,
                 {out1.meta, out1.data}, {in1.meta, in1.data}, int'(occ1), int'(hwm1), int'(ovf1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in0(input logic v);
    if (v) begin
      seq++;
      in0.data = {$urandom(), seq};
      in0.meta = phv_meta_t'(16'($urandom()));
    end
    in0.valid = v;
  endtask

  task automatic drive_in1(input logic v);
    if (v) begin
      seq++;
      in1.data = {$urandom(), seq};
      in1.meta = phv_meta_t'(16'($urandom()));
    end
    in1.valid = v;
  endtask

  initial begin
    int skid, cyc, fall_occ;
    logic [3:0] pipe;
    in0.valid = 1'b0; in0.data = '0; in0.meta = '0; out0.ready = 1'b1;
    in1.valid = 1'b0; in1.data = '0; in1.meta = '0; out1.ready = 1'b0;
    popn[0] = 0; popn[1] = 0; pushn[0] = 0; pushn[1] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst.in_ready", 128'(in0.ready), 128'(1));
    check_eq("rst.valid", 128'(out0.valid), 128'(0));
    check_eq("rst.occ", 128'(occ0), 128'(0));

    // Back-to-back stream with free-running downstream.
    out0.ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_in0(1'b1);
      step();
    end
    drive_in0(1'b0);
    repeat (3) step();
    check_eq("stream.pops", 128'(popn[0]), 128'(20));
    check_eq("stream.hwm", 128'(hwm0), 128'(1));
    check_eq("stream.occ", 128'(occ0), 128'(0));

    // Downstream stalled; upstream keeps going for 4 beats after ready drops.
    out0.ready = 1'b0;
    skid = 0; cyc = 0; fall_occ = -1;
    while (skid < 4 && cyc < 50) begin
      if (!in0.ready) begin
        if (fall_occ < 0) fall_occ = int'(occ0);
        skid++;
      end
      drive_in0(1'b1);
      step();
      cyc++;
    end
    drive_in0(1'b0);
    check_eq("stall.bound", 128'(cyc < 50), 128'(1));
    check_eq("stall.fall_occ", 128'(fall_occ), 128'(4));
    check_eq("stall.occ", 128'(occ0), 128'(8));
    check_eq("stall.ovf", 128'(ovf0), 128'(0));

    // Full with simultaneous push and pop.
    out0.ready = 1'b1;
    drive_in0(1'b1);
    step();
    out0.ready = 1'b0;
    drive_in0(1'b0);
    check_eq("fullpp.occ", 128'(occ0), 128'(8));
    check_eq("fullpp.ovf", 128'(ovf0), 128'(0));

    // Overflow: three pushes into a full buffer with no pop.
    for (int i = 0; i < 3; i++) begin
      drive_in0(1'b1);
      step();
    end
    drive_in0(1'b0);
    check_eq("ovf.cnt", 128'(ovf0), 128'(3));
    check_eq("ovf.occ", 128'(occ0), 128'(8));

    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    check_eq("clr.ovf", 128'(ovf0), 128'(0));
    check_eq("clr.hwm", 128'(hwm0), 128'(0));
    check_eq("clr.occ", 128'(occ0), 128'(8));

    // Drain three, then reset mid-stream with five held.
    out0.ready = 1'b1;
    repeat (3) step();
    out0.ready = 1'b0;
    step();
    check_eq("pre_rst.occ", 128'(occ0), 128'(5));
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst.valid", 128'(out0.valid), 128'(0));
    check_eq("arst.in_ready", 128'(in0.ready), 128'(1));
    check_eq("arst.occ", 128'(occ0), 128'(0));
    check_eq("arst.hwm", 128'(hwm0), 128'(0));
    check_eq("arst.ovf", 128'(ovf0), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out0.ready = 1'b1;

    // DEPTH=6 build behind a 4-cycle upstream pipe, random downstream stalls.
    pipe = '0;
    for (int i = 0; i < 1000; i++) begin
      out1.ready = ($urandom_range(0, 9) < 4);
      drive_in1(pipe[3]);
      pipe = {pipe[2:0], in1.ready & ($urandom_range(0, 3) != 0)};
      step();
    end
    for (int i = 0; i < 16; i++) begin
      out1.ready = 1'b1;
      drive_in1(pipe[3]);
      pipe = {pipe[2:0], 1'b0};
      step();
    end
    check_eq("rand.ovf", 128'(ovf1), 128'(0));
    check_eq("rand.hwm", 128'(hwm1), 128'(sbmax[1]));
    check_eq("rand.occ", 128'(occ1), 128'(0));
    check_eq("rand.balance", 128'(popn[1]), 128'(pushn[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
